sha512_msg_pad: RTL and testbench
=================================

// Module: sha512_msg_pad
// PURPOSE
//  Message front end for the SHA-512-family compression core. Accepts a message as a
//  stream of 64-bit big-endian words and applies FIPS 180-4 padding: 0x80, zero fill,
//  then a 128-bit message bit length. Emits 1024-bit blocks plus first/last flags over
//  a valid/ready handshake. Sits between the host/DMA stream and the core's Data input.
// PARAMETERS
//  LEN_W  64  bit-length counter width; length field = zero-extended to 128b, counter wraps mod 2^LEN_W
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     reset, synchronous, active-low
//  in_data    in   64    message word; byte 0 = in_data[63:56]
//  in_valid   in   1     in_data/in_last/in_bytes valid
//  in_ready   out  1     word accepted when in_valid & in_ready
//  in_last    in   1     final word of message
//  in_bytes   in   4     valid bytes in final word, 0..8 (MSB-first); ignored unless in_last
//  blk_data   out  1024  padded block; byte 0 = blk_data[1023:1016]
//  blk_valid  out  1     block available
//  blk_ready  in   1     block consumed when blk_valid & blk_ready
//  blk_first  out  1     first block of message (core loads IV)
//  blk_last   out  1     final block of message (Hash valid after it)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state FILL, word idx=0, len=0, buffer=0, in_ready=0 that
//    cycle then 1; blk_valid=0, blk_first=1 (pending), blk_last=0. Partial block discarded.
//  - States: FILL (in_ready=1, blk_valid=0), EMIT (in_ready=0, blk_valid=1), PADBLK (one
//    cycle: build length-only or 0x80-led block, in_ready=0, blk_valid=0) -> EMIT.
//  - FILL: accepted word written to word slot idx; idx++; len += 64 (or 8*in_bytes if in_last).
//  - Non-last word into slot 15 -> EMIT next cycle, blk_last=0 (latency 1 cycle).
//  - Last word: b = 8*idx + in_bytes (byte offset of pad start), bytes >= in_bytes of word zeroed.
//    b<=111: 0x80 at byte b, zeros, len at bytes 112..127 -> EMIT, blk_last=1.
//    112<=b<=127: 0x80 at b, zeros to 127 -> EMIT blk_last=0; then PADBLK = zeros + len, blk_last=1.
//    b==128: data-only block, blk_last=0; then PADBLK = 0x80 at byte 0, zeros, len, blk_last=1.
//  - Empty message: in_last with in_bytes=0 at idx=0 -> single block 0x80,0...,len=0.
//  - in_bytes>8 treated as 8. in_last word always ends the message; next word starts new one.
//  - EMIT: blk_data/blk_first/blk_last held stable while blk_valid & !blk_ready. On
//    handshake: blk_first<=0; buffer<=0, idx<=0; if blk_last: len<=0, blk_first<=1, ->FILL;
//    else if pad block pending ->PADBLK, else ->FILL.
//  - No bubble constraint beyond above: throughput 1 word/cycle in FILL, block-level stall
//    of >=1 cycle per emitted block.
//  - Length counts bits; overflow beyond LEN_W wraps silently.
// CONFIGURATION
//  SHA_PAD_BYTE_SWAP_EN defined: in_data byte-reversed before use (in_data[7:0] = byte 0),
//  valid bytes of final word are the in_bytes LSB bytes. Undefined: big-endian as above.
//  Output format identical in both builds.
// TESTING
//  1 "abc": word 0x6162630000000000, last, bytes=3 -> one block 0x61626380_00..00_0000..0018,
//    first=1 last=1.
//  2 Empty: last, bytes=0 -> one block 0x80 then zeros, length field 0, first=1 last=1.
//  3 112-byte msg (14 words) -> block A bytes 0..111 data, byte 112=0x80, last=0; block B
//    zeros + len 0x380, first=0 last=1.
//  4 128-byte msg -> block A pure data first=1 last=0; block B 0x80 at byte 0, len 0x400, last=1.
//  5 blk_ready low 5 cycles during EMIT -> blk_data/flags stable, in_ready=0, no word lost.
//  6 rst low after 7 words, then "abc" -> single correct "abc" block with first=1; with
//    SHA_PAD_BYTE_SWAP_EN word 0x0000000000636261 yields same block.

Source files
------------

// File: rtl/sha512_msg_pad_if.sv
// Message-word in / padded-block out handshake bundle for sha512_msg_pad.
// master = host/DMA side, slave = padding block.
interface sha512_msg_pad_if;
    logic [63:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic [1023:0] blk_data;
    logic          blk_valid;
    logic          blk_ready;
    logic          blk_first;
    logic          blk_last;

    modport master (
        output in_data, in_valid, in_last, in_bytes, blk_ready,
        input  in_ready, blk_data, blk_valid, blk_first, blk_last
    );

    modport slave (
        input  in_data, in_valid, in_last, in_bytes, blk_ready,
        output in_ready, blk_data, blk_valid, blk_first, blk_last
    );
endinterface

// File: rtl/sha512_msg_pad.sv
// SHA-512 message padder: packs 64-bit words into 1024-bit blocks with 0x80, zero fill and
// 128-bit bit length. Define SHA_PAD_BYTE_SWAP_EN for little-endian (byte 0 = LSB) input words.
module sha512_msg_pad #(
    parameter int LEN_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    sha512_msg_pad_if.slave bus
);
    typedef enum logic [1:0] {FILL, EMIT, PADBLK} state_e;

    state_e            state_q, state_d;
    logic [0:15][63:0] buf_q, buf_d;
    logic [3:0]        idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              in_ready_q, in_ready_d;
    logic              blk_valid_q, blk_valid_d;
    logic              blk_first_q, blk_first_d;
    logic              blk_last_q, blk_last_d;
    logic              pad_pend_q, pad_pend_d;
    logic              pad_lead_q, pad_lead_d;

    logic              accept;
    logic [63:0]       word;
    logic [63:0]       kept;
    logic [3:0]        nb;
    logic [7:0]        b;
    logic [LEN_W-1:0]  len_new;

`ifdef SHA_PAD_BYTE_SWAP_EN
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            word[63-8*i -: 8] = bus.in_data[8*i +: 8];
        end
    end
`else
    assign word = bus.in_data;
`endif

    always_comb begin
        // NOTE: every _d starts from its hold value so no path through this block infers a latch.
        state_d     = state_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        len_d       = len_q;
        blk_first_d = blk_first_q;
        blk_last_d  = blk_last_q;
        pad_pend_d  = pad_pend_q;
        pad_lead_d  = pad_lead_q;

        accept  = bus.in_valid & in_ready_q;
        nb      = (bus.in_bytes > 4'd8) ? 4'd8 : bus.in_bytes;
        b       = {1'b0, idx_q, 3'b000} + {4'b0000, nb};
        len_new = bus.in_last ? len_q + LEN_W'({nb, 3'b000}) : len_q + LEN_W'(64);
        kept    = word & ~(64'hFFFF_FFFF_FFFF_FFFF >> {nb, 3'b000});

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    len_d = len_new;
                    idx_d = idx_q + 4'd1;
                    if (!bus.in_last) begin
                        buf_d[idx_q] = word;
                        if (idx_q == 4'd15) begin
                            state_d    = EMIT;
                            blk_last_d = 1'b0;
                            pad_pend_d = 1'b0;
                        end
                    end else begin
                        // A full final word pushes the 0x80 marker into the next slot.
                        if (nb != 4'd8) begin
                            buf_d[idx_q] = kept | (64'h80 << {3'd7 - nb[2:0], 3'b000});
                        end else begin
                            buf_d[idx_q] = kept;
                            if (idx_q != 4'd15) buf_d[idx_q + 4'd1] = 64'h8000_0000_0000_0000;
                        end
                        state_d = EMIT;
                        if (b <= 8'd111) begin
                            buf_d[14:15] = 128'(len_new);
                            blk_last_d   = 1'b1;
                            pad_pend_d   = 1'b0;
                        end else begin
                            blk_last_d = 1'b0;
                            pad_pend_d = 1'b1;
                            pad_lead_d = (b == 8'd128);
                        end
                    end
                end
            end
            EMIT: begin
                if (bus.blk_ready) begin
                    blk_first_d = 1'b0;
                    buf_d       = '0;
                    idx_d       = 4'd0;
                    if (blk_last_q) begin
                        len_d       = '0;
                        blk_first_d = 1'b1;
                        state_d     = FILL;
                    end else if (pad_pend_q) begin
                        state_d = PADBLK;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            PADBLK: begin
                buf_d = '0;
                if (pad_lead_q) buf_d[0] = 64'h8000_0000_0000_0000;
                buf_d[14:15] = 128'(len_q);
                blk_last_d   = 1'b1;
                pad_pend_d   = 1'b0;
                state_d      = EMIT;
            end
            default: state_d = FILL;
        endcase

        in_ready_d  = (state_d == FILL);
        blk_valid_d = (state_d == EMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FILL;
            // NOTE: the block buffer is reset, not just idx, because zero fill relies on unwritten slots reading 0.
            buf_q       <= '0;
            idx_q       <= 4'd0;
            len_q       <= '0;
            in_ready_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_first_q <= 1'b1;
            blk_last_q  <= 1'b0;
            pad_pend_q  <= 1'b0;
            pad_lead_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge _d values regardless of statement order.
            state_q     <= state_d;
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            in_ready_q  <= in_ready_d;
            blk_valid_q <= blk_valid_d;
            blk_first_q <= blk_first_d;
            blk_last_q  <= blk_last_d;
            pad_pend_q  <= pad_pend_d;
            pad_lead_q  <= pad_lead_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.blk_data  = buf_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.blk_first = blk_first_q;
    assign bus.blk_last  = blk_last_q;
endmodule

// File: tb/tb_sha512_msg_pad.sv
// Directed bench for sha512_msg_pad: hand-computed padded blocks, stall and reset behaviour.
module tb_sha512_msg_pad;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_w [16];

    sha512_msg_pad_if bus ();

    sha512_msg_pad dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] to_bus(input logic [63:0] w);
`ifdef SHA_PAD_BYTE_SWAP_EN
        for (int i = 0; i < 8; i++) to_bus[8*i +: 8] = w[63-8*i -: 8];
`else
        to_bus = w;
`endif
    endfunction

    function automatic logic [63:0] dw(input int i);
        return 64'hA0A1_A2A3_A4A5_A600 | 64'(i);
    endfunction

    task automatic clear_exp();
        for (int k = 0; k < 16; k++) exp_w[k] = 64'd0;
    endtask

    task automatic send_word(input logic [63:0] w, input logic last, input logic [3:0] nbytes);
        int n = 0;
        @(negedge clk);
        bus.in_data  = to_bus(w);
        bus.in_last  = last;
        bus.in_bytes = nbytes;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic expect_blk(input string name, input logic first, input logic last, input bit ack);
        int n = 0;
        @(negedge clk);
        while (bus.blk_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " valid"}, 64'(bus.blk_valid), 64'd1);
        if (bus.blk_valid !== 1'b1) return;
        for (int k = 0; k < 16; k++)
            check($sformatf("%s w%0d", name, k), bus.blk_data[1023-64*k -: 64], exp_w[k]);
        check({name, " first"}, 64'(bus.blk_first), 64'(first));
        check({name, " last"}, 64'(bus.blk_last), 64'(last));
        check({name, " in_ready"}, 64'(bus.in_ready), 64'd0);
        if (ack) begin
            bus.blk_ready = 1'b1;
            @(posedge clk);
            #1 bus.blk_ready = 1'b0;
        end
    endtask

    task automatic set_abc_exp();
        clear_exp();
        exp_w[0]  = 64'h6162_6380_0000_0000;
        exp_w[15] = 64'h18;
    endtask

    initial begin
        int n;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_bytes  = '0;
        bus.blk_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 64'(bus.in_ready), 64'd0);
        check("rst blk_valid", 64'(bus.blk_valid), 64'd0);
        check("rst blk_first", 64'(bus.blk_first), 64'd1);
        check("rst blk_last", 64'(bus.blk_last), 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check("post-rst in_ready", 64'(bus.in_ready), 64'd1);

        // 1: "abc"
        set_abc_exp();
        send_word(64'h6162_6300_0000_0000, 1'b1, 4'd3);
        expect_blk("abc", 1'b1, 1'b1, 1'b1);

        // 2: empty message
        clear_exp();
        exp_w[0] = 64'h8000_0000_0000_0000;
        send_word(64'h0, 1'b1, 4'd0);
        expect_blk("empty", 1'b1, 1'b1, 1'b1);

        // 3: 112 bytes -> marker at byte 112, length in a second block
        clear_exp();
        for (int i = 0; i < 14; i++) exp_w[i] = dw(i);
        exp_w[14] = 64'h8000_0000_0000_0000;
        for (int i = 0; i < 13; i++) send_word(dw(i), 1'b0, 4'd0);
        send_word(dw(13), 1'b1, 4'd8);
        expect_blk("m112 A", 1'b1, 1'b0, 1'b1);
        clear_exp();
        exp_w[15] = 64'h380;
        expect_blk("m112 B", 1'b0, 1'b1, 1'b1);

        // 4: 128 bytes -> data-only block, then 0x80-led length block
        clear_exp();
        for (int i = 0; i < 16; i++) exp_w[i] = dw(i);
        for (int i = 0; i < 15; i++) send_word(dw(i), 1'b0, 4'd0);
        send_word(dw(15), 1'b1, 4'd8);
        expect_blk("m128 A", 1'b1, 1'b0, 1'b1);
        clear_exp();
        exp_w[0]  = 64'h8000_0000_0000_0000;
        exp_w[15] = 64'h400;
        expect_blk("m128 B", 1'b0, 1'b1, 1'b1);

        // in_bytes above 8 clamps to a full word
        clear_exp();
        exp_w[0]  = 64'h0123_4567_89AB_CDEF;
        exp_w[1]  = 64'h8000_0000_0000_0000;
        exp_w[15] = 64'h40;
        send_word(64'h0123_4567_89AB_CDEF, 1'b1, 4'd15);
        expect_blk("clamp", 1'b1, 1'b1, 1'b1);

        // 5: 13-byte message held for 5 cycles while the next message waits
        clear_exp();
        exp_w[0]  = 64'h0102_0304_0506_0708;
        exp_w[1]  = 64'h1112_1314_1580_0000;
        exp_w[15] = 64'h68;
        send_word(64'h0102_0304_0506_0708, 1'b0, 4'd0);
        send_word(64'h1112_1314_1516_1718, 1'b1, 4'd5);
        expect_blk("stall", 1'b1, 1'b1, 1'b0);
        bus.in_data  = to_bus(64'h6162_6300_0000_0000);
        bus.in_last  = 1'b1;
        bus.in_bytes = 4'd3;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("stall c%0d valid", c), 64'(bus.blk_valid), 64'd1);
            check($sformatf("stall c%0d w1", c), bus.blk_data[959:896], exp_w[1]);
            check($sformatf("stall c%0d w15", c), bus.blk_data[63:0], exp_w[15]);
            check($sformatf("stall c%0d flags", c), {62'd0, bus.blk_first, bus.blk_last}, 64'd3);
            check($sformatf("stall c%0d in_ready", c), 64'(bus.in_ready), 64'd0);
        end
        bus.blk_ready = 1'b1;
        @(posedge clk);
        #1 bus.blk_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall resume in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        set_abc_exp();
        expect_blk("after stall", 1'b1, 1'b1, 1'b1);

        // 6: reset mid-message discards the partial block
        for (int i = 0; i < 7; i++) send_word(dw(i), 1'b0, 4'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst blk_valid", 64'(bus.blk_valid), 64'd0);
        check("midrst blk_first", 64'(bus.blk_first), 64'd1);
        @(negedge clk) rst = 1'b1;
        set_abc_exp();
        send_word(64'h6162_6300_0000_0000, 1'b1, 4'd3);
        expect_blk("abc after rst", 1'b1, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
